// File: rtl/nx_node_loader.sv
// nx_node_loader: decodes fixed-width inbound messages into single-cycle
// load / input / tick pulses for a node core, gated on the core's state flags.
// Latency: a strobe appears exactly one cycle after the accepting edge.
// Backpressure: msg_ready is low while a TICK waits for, or waits out, core WAIT.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   msg_data/valid/ready        inbound message handshake
//   core_in_setup/wait/run      core state flags
//   load_instr/slot/last/valid  instruction-load interface to the core
//   in_value/index/valid        primary-input load interface to the core
//   tick                        run trigger pulse
//   instr_count, err_count      debug counters (both saturating)
module nx_node_loader #(
   parameter int OP_W   = 4,
   parameter int REG_W  = 16,
   parameter int IO_W   = 4,
   parameter int SLOTS  = 32,
   parameter int INST_W = OP_W + 3*$clog2(REG_W) + 1 + $clog2(IO_W),
   parameter int MSG_W  = 2 + 1 + $clog2(SLOTS) + INST_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [MSG_W-1:0]           msg_data,
   input  logic                       msg_valid,
   output logic                       msg_ready,
   input  logic                       core_in_setup,
   input  logic                       core_in_wait,
   input  logic                       core_in_run,
   output logic [INST_W-1:0]          load_instr,
   output logic [$clog2(SLOTS)-1:0]   load_slot,
   output logic                       load_last,
   output logic                       load_valid,
   output logic                       in_value,
   output logic [$clog2(IO_W)-1:0]    in_index,
   output logic                       in_valid,
   output logic                       tick,
   output logic [$clog2(SLOTS):0]     instr_count,
   output logic [7:0]                 err_count
);

   localparam int SLOT_W = $clog2(SLOTS);
   localparam int IDX_W  = $clog2(IO_W);
   localparam logic [SLOT_W:0] CNT_MAX = (SLOT_W+1)'(SLOTS);

   localparam logic [1:0] T_LOAD  = 2'd0;
   localparam logic [1:0] T_INPUT = 2'd1;
   localparam logic [1:0] T_TICK  = 2'd2;

   typedef enum logic [1:0] {IDLE, TICK_HOLD, TICK_SENT} state_t;
   state_t state;

   // Message field views
   logic [1:0]        f_type;
   logic              f_last;
   logic [SLOT_W-1:0] f_slot;
   logic [INST_W-1:0] f_instr;
   logic [IDX_W-1:0]  f_index;
   logic              f_value;

   assign f_type  = msg_data[MSG_W-1 -: 2];
   assign f_last  = msg_data[MSG_W-3];
   assign f_slot  = msg_data[MSG_W-4 -: SLOT_W];
   assign f_instr = msg_data[INST_W-1:0];
   assign f_index = msg_data[IDX_W:1];
   assign f_value = msg_data[0];

   // RUN is implied by the other two flags; inputs are accepted in any state,
   // so the loader has no use for it.
   logic unused_run;
   assign unused_run = core_in_run;

   // Ready depends only on state (and reset), never on the offered message.
   assign msg_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         load_instr  <= '0;
         load_slot   <= '0;
         load_last   <= 1'b0;
         load_valid  <= 1'b0;
         in_value    <= 1'b0;
         in_index    <= '0;
         in_valid    <= 1'b0;
         tick        <= 1'b0;
         instr_count <= '0;
         err_count   <= '0;
      end else begin
         // Strobes are one-cycle pulses; data outputs hold their last value.
         load_valid <= 1'b0;
         in_valid   <= 1'b0;
         tick       <= 1'b0;

         case (state)
            IDLE: begin
               if (msg_valid) begin
                  case (f_type)
                     T_LOAD: begin
                        if (core_in_setup) begin
                           load_instr <= f_instr;
                           load_slot  <= f_slot;
                           load_last  <= f_last;
                           load_valid <= 1'b1;
                           if (instr_count != CNT_MAX)
                              instr_count <= instr_count + 1'b1;
                        end else if (err_count != 8'hFF) begin
                           err_count <= err_count + 8'd1;
                        end
                     end
                     T_INPUT: begin
                        in_index <= f_index;
                        in_value <= f_value;
                        in_valid <= 1'b1;
                     end
                     T_TICK: begin
                        if (core_in_wait) begin
                           tick  <= 1'b1;
                           state <= TICK_SENT;
                        end else begin
                           state <= TICK_HOLD;
                        end
                     end
                     default: begin
                        if (err_count != 8'hFF)
                           err_count <= err_count + 8'd1;
                     end
                  endcase
               end
            end
            TICK_HOLD: begin
               if (core_in_wait) begin
                  tick  <= 1'b1;
                  state <= TICK_SENT;
               end
            end
            TICK_SENT: begin
               // Stay busy until the core has left WAIT, so a queued TICK
               // cannot fire again before the core actually starts running.
               if (!core_in_wait)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nx_node_loader.sv
module tb_nx_node_loader;

   localparam int SLOTS  = 32;
   localparam int SLOT_W = 5;
   localparam int IDX_W  = 2;
   localparam int INST_W = 19;
   localparam int MSG_W  = 27;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [MSG_W-1:0]  msg_data = '0;
   logic              msg_valid = 1'b0;
   logic              msg_ready;
   logic              core_in_setup = 1'b0;
   logic              core_in_wait = 1'b0;
   logic              core_in_run = 1'b0;
   logic [INST_W-1:0] load_instr;
   logic [SLOT_W-1:0] load_slot;
   logic              load_last;
   logic              load_valid;
   logic              in_value;
   logic [IDX_W-1:0]  in_index;
   logic              in_valid;
   logic              tick;
   logic [SLOT_W:0]   instr_count;
   logic [7:0]        err_count;

   nx_node_loader dut (
      .clk(clk), .rst(rst),
      .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .core_in_setup(core_in_setup), .core_in_wait(core_in_wait), .core_in_run(core_in_run),
      .load_instr(load_instr), .load_slot(load_slot), .load_last(load_last), .load_valid(load_valid),
      .in_value(in_value), .in_index(in_index), .in_valid(in_valid),
      .tick(tick), .instr_count(instr_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int tick_seen = 0;

   // Count tick pulses shortly after each edge, away from the comparisons.
   always @(posedge clk) begin
      #1;
      if (tick === 1'b1) tick_seen++;
   end

   // Reference model state: what the core should have been told so far.
   int                m_cnt, m_err;
   logic [INST_W-1:0] m_instr;
   logic [SLOT_W-1:0] m_slot;
   logic              m_last, m_val;
   logic [IDX_W-1:0]  m_idx;

   task automatic model_reset();
      m_cnt = 0; m_err = 0; m_instr = '0; m_slot = '0;
      m_last = 0; m_val = 0; m_idx = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [MSG_W-1:0] mk(input int t, input int last, input int slot, input int instr);
      logic [MSG_W-1:0] m;
      m = '0;
      m[MSG_W-1 -: 2]  = t[1:0];
      m[MSG_W-3]       = last[0];
      m[MSG_W-4 -: SLOT_W] = slot[SLOT_W-1:0];
      m[INST_W-1:0]    = instr[INST_W-1:0];
      return m;
   endfunction

   function automatic logic [MSG_W-1:0] mk_in(input int idx, input int val);
      logic [MSG_W-1:0] m;
      m = '0;
      m[MSG_W-1 -: 2] = 2'd1;
      m[IDX_W:1]      = idx[IDX_W-1:0];
      m[0]            = val[0];
      return m;
   endfunction

   // Wait (bounded) for ready at a falling edge, then present m for one edge.
   task automatic offer(input logic [MSG_W-1:0] m);
      int n;
      n = 0;
      while (msg_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (msg_ready !== 1'b1) chk("ready_timeout", {31'd0, msg_ready}, 32'd1);
      msg_data  = m;
      msg_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      msg_valid = 1'b0;
   endtask

   // Send a non-TICK message and check the cycle after acceptance against the model.
   task automatic xfer(input logic [MSG_W-1:0] m);
      int t;
      logic exp_lv, exp_iv;
      t = int'(m[MSG_W-1 -: 2]);
      exp_lv = 0; exp_iv = 0;
      offer(m);
      if (t == 0) begin
         if (core_in_setup) begin
            exp_lv = 1; m_instr = m[INST_W-1:0]; m_slot = m[MSG_W-4 -: SLOT_W];
            m_last = m[MSG_W-3];
            if (m_cnt < SLOTS) m_cnt++;
         end else if (m_err < 255) m_err++;
      end else if (t == 1) begin
         exp_iv = 1; m_idx = m[IDX_W:1]; m_val = m[0];
      end else if (m_err < 255) m_err++;
      chk("load_valid", {31'd0, load_valid}, {31'd0, exp_lv});
      chk("in_valid",   {31'd0, in_valid},   {31'd0, exp_iv});
      chk("tick_quiet", {31'd0, tick}, 32'd0);
      chk("load_instr", 32'(load_instr), 32'(m_instr));
      chk("load_slot",  32'(load_slot),  32'(m_slot));
      chk("load_last",  {31'd0, load_last}, {31'd0, m_last});
      chk("in_index",   32'(in_index),   32'(m_idx));
      chk("in_value",   {31'd0, in_value}, {31'd0, m_val});
      chk("instr_count", 32'(instr_count), m_cnt);
      chk("err_count",  32'(err_count), m_err);
      chk("ready_after", {31'd0, msg_ready}, 32'd1);
      @(negedge clk);
      chk("strobe_drop", {30'd0, load_valid, in_valid}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ready_in_rst", {31'd0, msg_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      chk("rst_ready",  {31'd0, msg_ready}, 32'd1);
      chk("rst_strobe", {29'd0, load_valid, in_valid, tick}, 32'd0);
      chk("rst_data",   {load_instr, load_slot, load_last, in_value, in_index}, 32'd0);
      chk("rst_cnt",    {18'd0, instr_count, err_count}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int tk;
      model_reset();
      @(negedge clk);
      do_reset();

      // Instruction loads during SETUP.
      core_in_setup = 1;
      for (int s = 0; s < 3; s++) xfer(mk(0, (s == 2) ? 1 : 0, s, 'h1A2B3));
      chk("cnt_three", 32'(instr_count), 32'd3);

      // LOAD outside SETUP is dropped.
      core_in_setup = 0; core_in_wait = 1;
      xfer(mk(0, 0, 7, 'h5555));
      chk("err_one", 32'(err_count), 32'd1);

      // INPUT accepted while running.
      core_in_wait = 0; core_in_run = 1;
      xfer(mk_in(3, 1));
      chk("in_idx3", 32'(in_index), 32'd3);

      // TICK held until the core enters WAIT.
      tk = tick_seen;
      offer(mk(2, 0, 0, 0));
      chk("hold_ready", {31'd0, msg_ready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_notick", {31'd0, tick}, 32'd0);
      end
      core_in_run = 0; core_in_wait = 1;
      @(negedge clk);
      chk("hold_tick", {31'd0, tick}, 32'd1);
      chk("sent_ready", {31'd0, msg_ready}, 32'd0);
      @(negedge clk);
      chk("sent_notick", {31'd0, tick}, 32'd0);
      chk("sent_ready2", {31'd0, msg_ready}, 32'd0);
      core_in_wait = 0; core_in_run = 1;
      @(negedge clk);
      chk("back_ready", {31'd0, msg_ready}, 32'd1);
      chk("tick_once", tick_seen - tk, 32'd1);

      // Back-to-back TICKs with WAIT held after the first.
      tk = tick_seen;
      core_in_run = 0; core_in_wait = 1;
      offer(mk(2, 0, 0, 0));
      chk("b2b_tick1", {31'd0, tick}, 32'd1);
      msg_data = mk(2, 0, 0, 0); msg_valid = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("b2b_blocked", {31'd0, msg_ready}, 32'd0);
         chk("b2b_notick", {31'd0, tick}, 32'd0);
      end
      core_in_wait = 0; core_in_run = 1;
      @(negedge clk);
      chk("b2b_ready", {31'd0, msg_ready}, 32'd1);
      @(negedge clk);
      msg_valid = 0;
      chk("b2b_held", {30'd0, msg_ready, tick}, 32'd0);
      core_in_run = 0; core_in_wait = 1;
      @(negedge clk);
      chk("b2b_tick2", {31'd0, tick}, 32'd1);
      core_in_wait = 0; core_in_run = 1;
      @(negedge clk);
      @(negedge clk);
      chk("b2b_count", tick_seen - tk, 32'd2);

      // Randomized non-TICK traffic against the model.
      for (int i = 0; i < 150; i++) begin
         int t;
         t = int'($urandom_range(0, 2));
         if (t == 2) t = 3;
         core_in_setup = $urandom_range(0, 1) == 1;
         core_in_run   = !core_in_setup;
         xfer(mk(t, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, (1 << INST_W) - 1))));
      end

      // instr_count saturates at SLOTS.
      core_in_setup = 1; core_in_run = 0;
      for (int i = 0; i < 35; i++) xfer(mk(0, 0, i % 32, i));
      chk("cnt_sat", 32'(instr_count), 32'(SLOTS));

      // Reset while a TICK is held: nothing pending may survive.
      core_in_setup = 0; core_in_wait = 0; core_in_run = 1;
      offer(mk(2, 0, 0, 0));
      chk("rst_hold", {31'd0, msg_ready}, 32'd0);
      tk = tick_seen;
      core_in_run = 0; core_in_wait = 1;
      do_reset();
      @(negedge clk);
      chk("rst_no_tick", tick_seen - tk, 32'd0);
      core_in_wait = 0;

      // err_count saturates at 255.
      for (int i = 0; i < 300; i++) xfer(mk(3, 0, i, i));
      chk("err_sat", 32'(err_count), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
